// File: rtl/la_onehot5_chk.sv
// One-hot legality check for the 5-bit channel select.
// PROP picks between two equivalent formulations so implementation can steer mapping.
module la_onehot5_chk #(
  parameter string PROP = "DEFAULT"
) (
  input  logic [4:0] sel,
  output logic       legal
);

  generate
    if (PROP == "POPCOUNT") begin : g_popcount
      assign legal = ($countones(sel) == 1);
    end else begin : g_pow2
      // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
      assign legal = (sel != 5'd0) && ((sel & (sel - 5'd1)) == 5'd0);
    end
  endgenerate

endmodule

// File: rtl/la_demux5_stream.sv
// Five-way stream demultiplexer with a two-entry (main + skid) buffer.
// Words with a non-one-hot select are dropped, counted and flagged.
module la_demux5_stream #(
  parameter int    WIDTH = 8,
  parameter string PROP  = "DEFAULT"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_sel,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [7:0]       drop_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Handshake: a transfer happens on any cycle where valid and ready are both 1.
  // in_ready is registered (NOT TWO) and forced low while rst is asserted.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data, w_main_data_nxt;
  logic [4:0]       r_main_sel,  w_main_sel_nxt;
  logic [WIDTH-1:0] r_skid_data, w_skid_data_nxt;
  logic [4:0]       r_skid_sel,  w_skid_sel_nxt;
  logic             r_in_ready;
  logic             r_err;
  logic [7:0]       r_drop_count;

  logic w_legal;
  logic w_in_fire;
  logic w_accept;
  logic w_drop;
  logic w_drain;

  la_onehot5_chk #(.PROP(PROP)) u_chk (
    .sel   (in_sel),
    .legal (w_legal)
  );

  assign in_ready  = r_in_ready & ~rst;
  assign w_in_fire = in_valid & in_ready;
  assign w_accept  = w_in_fire & w_legal;
  assign w_drop    = w_in_fire & ~w_legal;
  // Only the head word's own channel ready matters; other lanes are ignored.
  assign w_drain   = (r_state != ST_EMPTY) && ((r_main_sel & out_ready) != 5'd0);

  assign out_valid  = (r_state != ST_EMPTY) ? r_main_sel : 5'd0;
  assign out_data   = r_main_data;
  assign err        = r_err;
  assign drop_count = r_drop_count;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_sel_nxt  = r_main_sel;
    w_skid_data_nxt = r_skid_data;
    w_skid_sel_nxt  = r_skid_sel;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = ST_ONE;
          w_main_data_nxt = in_data;
          w_main_sel_nxt  = in_sel;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_main_data_nxt = in_data;
          w_main_sel_nxt  = in_sel;
        end else if (w_accept) begin
          w_state_nxt     = ST_TWO;
          w_skid_data_nxt = in_data;
          w_skid_sel_nxt  = in_sel;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can occur.
        if (w_drain) begin
          w_state_nxt     = ST_ONE;
          w_main_data_nxt = r_skid_data;
          w_main_sel_nxt  = r_skid_sel;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_in_ready   <= 1'b1;
      r_err        <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
      if (w_drop) begin
        r_err <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // Payload storage needs no reset: it is only observed while the state says it is full.
  always_ff @(posedge clk) begin
    r_main_data <= w_main_data_nxt;
    r_main_sel  <= w_main_sel_nxt;
    r_skid_data <= w_skid_data_nxt;
    r_skid_sel  <= w_skid_sel_nxt;
  end

endmodule

// File: tb/tb_la_demux5_stream.sv
// Randomized and directed bench for la_demux5_stream against a queue-based reference model.
module tb_la_demux5_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [4:0]   in_sel = '0;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready = '0;
  logic [W-1:0] out_data;
  logic         err;
  logic [7:0]   drop_count;

  la_demux5_stream #(.WIDTH(W), .PROP("DEFAULT")) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of {sel, data} with capacity 2, sticky error, saturating drop count.
  logic [W+4:0] exp_q[$];
  logic         m_err = 1'b0;
  int           m_drop = 0;
  bit           checking = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic [4:0] s,
                      input logic [4:0] rdy, input logic r);
    logic [W+4:0] head;
    logic [4:0]   exp_valid;
    logic         exp_rdy;
    logic         acc;
    @(negedge clk);
    if (checking) begin
      exp_rdy   = !rst && (exp_q.size() < 2);
      exp_valid = 5'd0;
      if (exp_q.size() > 0) begin
        head      = exp_q[0];
        exp_valid = head[W+4:W];
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("out_valid", {27'd0, out_valid}, {27'd0, exp_valid});
      if (exp_q.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, head[W-1:0]});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("drop_count", {24'd0, drop_count}, m_drop);
    end
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = rdy;
    rst       = r;
    if (r && checking) begin
      #1 check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    end
    acc = v && !r && (exp_q.size() < 2);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_err    = 1'b0;
      m_drop   = 0;
      checking = 1'b1;
    end else begin
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if ((rdy & head[W+4:W]) != 5'd0) void'(exp_q.pop_front());
      end
      if (acc) begin
        if ($countones(s) == 1) exp_q.push_back({s, d});
        else begin
          m_err = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  endtask

  function automatic logic [4:0] illegal_sel();
    logic [4:0] s;
    do s = 5'($urandom_range(0, 31)); while ($countones(s) == 1);
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Single word to channel 2.
    step(1, 8'hA5, 5'b00100, 5'b00000, 0);
    step(0, 0, 0, 5'b00100, 0);
    step(0, 0, 0, 5'b11111, 0);

    // Backpressure on channel 0: third word stalls until release.
    step(1, 8'h10, 5'b00001, 0, 0);
    step(1, 8'h11, 5'b00001, 0, 0);
    step(1, 8'h12, 5'b00001, 0, 0);
    step(1, 8'h12, 5'b00001, 5'b00001, 0);
    step(0, 0, 0, 5'b00001, 0);
    step(0, 0, 0, 5'b00001, 0);
    step(0, 0, 0, 5'b00001, 0);

    // Streaming with all lanes ready.
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 5'(1 << (i % 5)), 5'b11111, 0);
    step(0, 0, 0, 5'b11111, 0);
    step(0, 0, 0, 5'b11111, 0);

    // Illegal selects, then saturation of the drop counter.
    step(1, 8'hE0, 5'b00000, 5'b11111, 0);
    step(1, 8'hE1, 5'b00011, 5'b11111, 0);
    step(0, 0, 0, 5'b11111, 0);
    check("drop_two", {24'd0, drop_count}, 32'd2);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), illegal_sel(), 5'($urandom), 0);
    step(0, 0, 0, 0, 0);
    check("drop_sat", {24'd0, drop_count}, 32'd255);

    // Reset while TWO words are buffered: they must never appear.
    step(1, 8'hC1, 5'b10000, 0, 0);
    step(1, 8'hC2, 5'b10000, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 5'b11111, 0);
    check("err_after_rst", {31'd0, err}, 32'd0);
    step(0, 0, 0, 5'b11111, 0);

    // Head-of-line: channel-3 word waits behind a stalled channel-1 word.
    step(1, 8'h31, 5'b00010, 5'b01000, 0);
    step(1, 8'h33, 5'b01000, 5'b01000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 5'b01000, 0);
    step(0, 0, 0, 5'b00010, 0);
    step(0, 0, 0, 5'b01000, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic with occasional illegal selects and resets.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] s;
      if ($urandom_range(0, 7) == 0) s = illegal_sel();
      else s = 5'(1 << $urandom_range(0, 4));
      step($urandom_range(0, 3) != 0, 8'($urandom), s, 5'($urandom_range(0, 31)),
           $urandom_range(0, 149) == 0);
    end
    step(0, 0, 0, 5'b11111, 0);
    step(0, 0, 0, 5'b11111, 0);
    step(0, 0, 0, 5'b11111, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/la_demux5_stream.md
LA_DEMUX5_STREAM -- requirements
Module: la_demux5_stream

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and sets the data width.
REQ-002 Parameter PROP SHALL default to "DEFAULT" and is the cell property string passed through for implementation.
REQ-003 Port clk SHALL be an input, 1 bit, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, and is the reset: synchronous, active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit, and means the upstream word is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit, and means the block can accept a word this cycle.
REQ-007 Port in_data SHALL be an input, WIDTH bits, and is the upstream payload.
REQ-008 Port in_sel SHALL be an input, 5 bits, and is the one-hot destination channel select.
REQ-009 Port out_valid SHALL be an output, 5 bits, and is the per-channel valid.
REQ-010 Port out_ready SHALL be an input, 5 bits, and is the per-channel ready.
REQ-011 Port out_data SHALL be an output, WIDTH bits, and is the payload bus shared by all channels.
REQ-012 Port err SHALL be an output, 1 bit, and is a sticky flag set when a non-one-hot select is seen.
REQ-013 Port drop_count SHALL be an output, 8 bits, and counts dropped words.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1, in_ready=1, and rst=0.
REQ-015 An output transfer on channel i SHALL occur on a cycle with out_valid[i]=1 and out_ready[i]=1; out_ready[j] for j!=i SHALL be ignored.
REQ-016 A two-entry buffer (main, skid) SHALL hold data plus the 5-bit select; states: EMPTY, ONE (main full), TWO (main and skid full).
REQ-017 out_valid SHALL equal main_sel when main is full, and 5'b0 otherwise; at most one bit is ever set.
REQ-018 out_data SHALL equal main_data, and both SHALL stay stable while out_valid!=0 and the transfer is not taken.
REQ-019 in_ready SHALL be a registered signal equal to NOT(state==TWO), and SHALL be 0 while rst=1.
REQ-020 Latency from an accepted input to the corresponding out_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-021 Transitions SHALL be as follows:
- EMPTY, accept: go to ONE.
- ONE, accept without drain: go to TWO.
- ONE, accept with drain: stay ONE with the new word in main.
- ONE, drain without accept: go to EMPTY.
- TWO, drain: skid moves to main and the state goes to ONE.
REQ-022 Sustained throughput SHALL be 1 word per cycle when the destination ready is held high.
REQ-023 Words SHALL leave in acceptance order regardless of channel; there is no reordering and no bypass of a stalled head word.
REQ-024 An accepted word whose in_sel is not exactly one-hot (all zeros or 2+ bits set) SHALL be consumed and discarded, SHALL NOT enter the buffer, and SHALL NOT change state.
REQ-025 Each discarded word SHALL set err=1 and increment drop_count by 1.
REQ-026 err SHALL stay set until reset.
REQ-027 drop_count SHALL saturate at 255.
REQ-028 in_sel, in_data, and out_ready SHALL be treated as don't-care when the associated valid is 0.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL enter EMPTY and set out_valid=0, in_ready=0, err=0, and drop_count=0; out_data is don't-care.
REQ-030 Reset mid-operation SHALL discard all buffered words without emitting them; in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-031 No shared package SHALL be required; the state encoding SHALL be local constants within the module.
REQ-032 The one-hot legality check SHALL be a single combinational sub-module, la_onehot5_chk (input 5 bits, output legal).

Verification
REQ-033 Single word: after reset, send in_sel=5'b00100 with in_data=8'hA5 -> next cycle out_valid=5'b00100 and out_data=8'hA5; with out_ready[2]=1 the block is EMPTY a cycle later.
REQ-034 Backpressure: send 3 words to channel 0 with out_ready=0 -> in_ready drops after 2 accepts; on release, the words emerge in order, 1 per cycle.
REQ-035 Streaming: send 10 back-to-back words rotating channels 0..4 with all ready=1 -> 10 outputs on consecutive cycles, in_ready constantly 1.
REQ-036 Illegal select: send in_sel=5'b00000, then 5'b00011 -> no out_valid, err=1, drop_count=2; send 300 illegal words -> drop_count=255.
REQ-037 Reset mid-operation: fill TWO, then pulse rst for 1 cycle -> out_valid=0, err=0, in_ready=1 after rst; the old words never appear.
REQ-038 Head-of-line: main holds a channel-1 word with out_ready[1]=0 and out_ready[3]=1 -> the skid word for channel 3 is not emitted until channel 1 drains.
